// File: rtl/priority_arbiter_enc.sv
// Priority arbiter with registered, handshaked grant output.
// Fixed mode: the highest set request wins. Round-robin mode: the search runs downward from a
// pointer, and the pointer moves just below each accepted grant.
module priority_arbiter_enc #(
  parameter int unsigned N  = 8,
  parameter int unsigned RR = 0,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         gnt_ready,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot,
  output logic [15:0]  accept_cnt
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic [W-1:0]   idx_q, idx_d;
  logic [N-1:0]   onehot_q, onehot_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [W-1:0]   sel_idx;
  logic [W-1:0]   cand;
  logic           accept;
  logic           any_req;
  logic           load;

  // Handshake decode and pointer update; a same-cycle selection sees the updated pointer.
  always_comb begin
    accept  = (state_q == StHold) && gnt_ready;
    any_req = |req;
    load    = any_req && ((state_q == StIdle) || accept);
    ptr_d   = ptr_q;
    if (RR != 0 && accept) begin
      ptr_d = idx_q - W'(1);
    end
  end

  // Search order ptr_d, ptr_d-1, ... wrapping; later loop iterations have higher priority.
  always_comb begin
    sel_idx = ptr_d;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = ptr_d - W'(k);
      if (req[cand]) begin
        sel_idx = cand;
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    cnt_d    = cnt_q;
    if (accept) begin
      cnt_d = cnt_q + 16'd1;
    end
    if (load) begin
      state_d           = StHold;
      idx_d             = sel_idx;
      onehot_d          = '0;
      onehot_d[sel_idx] = 1'b1;
    end else if (accept) begin
      // Drain: drop valid and one-hot, keep the last index visible.
      state_d  = StIdle;
      onehot_d = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      ptr_q    <= W'(N - 1);
      idx_q    <= '0;
      onehot_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt_valid  = (state_q == StHold);
  assign gnt_idx    = idx_q;
  assign gnt_onehot = onehot_q;
  assign accept_cnt = cnt_q;

endmodule

// File: tb/tb_priority_arbiter_enc.sv
// Bench for priority_arbiter_enc: a fixed-priority and a round-robin instance share the same
// stimulus and are compared each cycle against a behavioural model, plus directed literal checks.
module tb_priority_arbiter_enc;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         gnt_ready;

  logic         gv_f, gv_r;
  logic [2:0]   gi_f, gi_r;
  logic [N-1:0] go_f, go_r;
  logic [15:0]  gc_f, gc_r;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 0;

  priority_arbiter_enc #(.N(N), .RR(0)) u_fix (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt_ready  (gnt_ready),
    .gnt_valid  (gv_f),
    .gnt_idx    (gi_f),
    .gnt_onehot (go_f),
    .accept_cnt (gc_f)
  );

  priority_arbiter_enc #(.N(N), .RR(1)) u_rr (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt_ready  (gnt_ready),
    .gnt_valid  (gv_r),
    .gnt_idx    (gi_r),
    .gnt_onehot (go_r),
    .accept_cnt (gc_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: index 0 = fixed priority, index 1 = round-robin.
  bit          m_valid[2];
  int          m_idx[2];
  int          m_ptr[2];
  logic [15:0] m_cnt[2];

  // First set bit scanning ptr, ptr-1, ... with wraparound.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p - k + N) % N;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        m_valid[m] = 0;
        m_idx[m]   = 0;
        m_ptr[m]   = N - 1;
        m_cnt[m]   = 16'd0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        bit acc;
        acc = m_valid[m] && gnt_ready;
        if (acc) begin
          m_cnt[m] = m_cnt[m] + 16'd1;
          if (m == 1) m_ptr[m] = (m_idx[m] + N - 1) % N;
        end
        if (!m_valid[m] || acc) begin
          if (req != 0) begin
            m_valid[m] = 1;
            m_idx[m]   = pick(req, m_ptr[m]);
          end else begin
            m_valid[m] = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [N-1:0] eo0, eo1;
      eo0 = m_valid[0] ? (N'(1) << m_idx[0]) : '0;
      eo1 = m_valid[1] ? (N'(1) << m_idx[1]) : '0;
      check("fix_valid", 32'(gv_f), 32'(m_valid[0]));
      check("fix_idx", 32'(gi_f), 32'(m_idx[0]));
      check("fix_onehot", 32'(go_f), 32'(eo0));
      check("fix_cnt", 32'(gc_f), 32'(m_cnt[0]));
      check("rr_valid", 32'(gv_r), 32'(m_valid[1]));
      check("rr_idx", 32'(gi_r), 32'(m_idx[1]));
      check("rr_onehot", 32'(go_r), 32'(eo1));
      check("rr_cnt", 32'(gc_r), 32'(m_cnt[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    gnt_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_fix_valid"}, 32'(gv_f), 0);
    check({tag, "_fix_idx"}, 32'(gi_f), 0);
    check({tag, "_fix_onehot"}, 32'(go_f), 0);
    check({tag, "_fix_cnt"}, 32'(gc_f), 0);
    check({tag, "_rr_valid"}, 32'(gv_r), 0);
    check({tag, "_rr_idx"}, 32'(gi_r), 0);
    check({tag, "_rr_cnt"}, 32'(gc_r), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req = '0;
    gnt_ready = 1'b0;
    #1 rst = 1'b0;
    #1 check_cleared("reset");
    cmp_en = 1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("idle_noreq_valid", 32'(gv_f), 0);

    // Fixed priority: highest set bit wins and repeats; round-robin rotates.
    req = 8'b0010_1100;
    gnt_ready = 1'b1;
    tick();
    check("fp_idx_a", 32'(gi_f), 5);
    check("fp_onehot_a", 32'(go_f), 32'h20);
    check("fp_valid_a", 32'(gv_f), 1);
    check("rr_idx_a", 32'(gi_r), 5);
    tick();
    check("fp_idx_b", 32'(gi_f), 5);
    check("rr_idx_b", 32'(gi_r), 3);
    tick();
    check("rr_idx_c", 32'(gi_r), 2);

    // Round-robin full rotation with all requests asserted.
    do_reset();
    req = 8'hFF;
    gnt_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("rr_seq_idx", 32'(gi_r), 32'((7 - i + 8) % 8));
    end
    tick();
    check("rr_seq_cnt", 32'(gc_r), 9);

    // Stall: grant held stable while req changes.
    do_reset();
    req = 8'h08;
    gnt_ready = 1'b1;
    tick();
    check("stall_idx0", 32'(gi_f), 3);
    gnt_ready = 1'b0;
    req = 8'h80;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_fix_idx", 32'(gi_f), 3);
      check("stall_fix_valid", 32'(gv_f), 1);
      check("stall_rr_idx", 32'(gi_r), 3);
    end
    gnt_ready = 1'b1;
    tick();
    check("stall_next_fix", 32'(gi_f), 7);
    check("stall_next_rr", 32'(gi_r), 7);

    // Drain to idle after the last request is accepted.
    do_reset();
    req = 8'h01;
    gnt_ready = 1'b1;
    tick();
    check("drain_idx", 32'(gi_f), 0);
    check("drain_valid1", 32'(gv_f), 1);
    req = 8'h00;
    tick();
    check("drain_valid0", 32'(gv_f), 0);
    check("drain_onehot0", 32'(go_f), 0);
    check("drain_cnt", 32'(gc_f), 1);
    tick();
    check("drain_stay_idle", 32'(gv_r), 0);

    // Asynchronous reset in the middle of a hold.
    do_reset();
    req = 8'hFF;
    gnt_ready = 1'b1;
    tick();
    tick();
    tick();
    check("arst_pre_rr", 32'(gi_r), 5);
    #2 rst = 1'b0;
    #1 check_cleared("arst");
    tick();
    rst = 1'b1;
    tick();
    check("arst_restart_rr", 32'(gi_r), 7);
    check("arst_restart_cnt", 32'(gc_r), 0);

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int c = 0; c < 3000; c++) begin
      case ($urandom % 4)
        0: req = '0;
        1: req = N'(1) << ($urandom % N);
        default: req = N'($urandom);
      endcase
      gnt_ready = ($urandom % 3) != 0;
      tick();
      if ($urandom % 500 == 0) begin
        #2 rst = 1'b0;
        #1 rst = 1'b1;
      end
    end

    // Accept counter wraps after 65536 accepts.
    do_reset();
    req = 8'hFF;
    gnt_ready = 1'b1;
    tick();
    repeat (65536) tick();
    check("wrap_fix_cnt", 32'(gc_f), 0);
    check("wrap_rr_cnt", 32'(gc_r), 0);

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
